// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // One register-file write: destination plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small ring-buffer FIFO holding long-latency results until the write port is free.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int Q_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Q_DEPTH+1)-1:0] count,
  output wb_req_t                      head
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  wb_req_t          mem [Q_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(Q_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_ptr];

  // Pointers and occupancy; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; empty slots are never read out as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the primary writeback path and
// the long-latency unit, and tracks outstanding long-latency destinations for hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pri_wr_en,
  input  logic [ADDR_W-1:0] pri_addr,
  input  logic [DATA_W-1:0] pri_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  input  logic [ADDR_W-1:0] chk_rd,
  input  logic              chk_rd_en,
  output logic              stall,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                err_q;
  logic                err_nxt;

  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  wb_req_t             fifo_head;
  wb_req_t             lu_req;

  logic                lu_accept;
  logic                sel_pri;
  logic                sel_head;
  logic                sel_byp;
  logic                lu_retire;
  logic                fifo_push;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  assign lu_req    = '{addr: lu_addr, data: lu_data};
  assign lu_ready  = rst && !fifo_full;
  assign lu_accept = lu_valid && lu_ready;
  assign fifo_push = lu_accept && !sel_byp;

  wb_fifo #(.Q_DEPTH(Q_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lu_req),
    .pop       (sel_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Pick the write-port owner: primary first, then queued results, then zero-latency bypass.
  always_comb begin
    sel_pri  = pri_wr_en && (pri_addr != ZERO_REG);
    sel_head = !sel_pri && !fifo_empty;
    sel_byp  = !sel_pri && fifo_empty && lu_accept;
    wr_addr  = ZERO_REG;
    wr_data  = '0;
    if (sel_pri) begin
      wr_addr = pri_addr;
      wr_data = pri_data;
    end else if (sel_head) begin
      wr_addr = fifo_head.addr;
      wr_data = fifo_head.data;
    end else if (sel_byp) begin
      wr_addr = lu_addr;
      wr_data = lu_data;
    end
    lu_retire = (sel_head || sel_byp) && (wr_addr != ZERO_REG);
    rf_wr_en  = rst && (wr_addr != ZERO_REG);
    rf_addr   = rf_wr_en ? wr_addr : ZERO_REG;
    rf_din    = rf_wr_en ? wr_data : '0;
  end

  // Scoreboard update: retire clears, issue sets afterwards so a same-address issue wins.
  always_comb begin
    pending_nxt = pending;
    err_nxt     = err_q;
    if (lu_retire) begin
      if (!pending[wr_addr]) err_nxt = 1'b1;
      pending_nxt[wr_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != ZERO_REG)) pending_nxt[issue_addr] = 1'b1;
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      err_q   <= err_nxt;
    end
  end

  // Hazard detection against registered pending bits only, so a retire never releases a stall early.
  always_comb begin
    stall = rst && (pending[chk_rs] || pending[chk_rt] ||
                    (chk_rd_en && pending[chk_rd]) ||
                    (issue_valid && pending[issue_addr]));
  end

  assign busy = rst && (!fifo_empty || (pending != '0));
  assign err  = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int Q_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pri_wr_en;
  logic [ADDR_W-1:0] pri_addr;
  logic [DATA_W-1:0] pri_data;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] chk_rs;
  logic [ADDR_W-1:0] chk_rt;
  logic [ADDR_W-1:0] chk_rd;
  logic              chk_rd_en;
  logic              stall;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_din;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of waiting results, set of pending registers, sticky error.
  wb_req_t    mq[$];
  bit [31:0]  mpend;
  bit         merr;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.Q_DEPTH(Q_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pri_wr_en   (pri_wr_en),
    .pri_addr    (pri_addr),
    .pri_data    (pri_data),
    .lu_valid    (lu_valid),
    .lu_addr     (lu_addr),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .chk_rs      (chk_rs),
    .chk_rt      (chk_rt),
    .chk_rd      (chk_rd),
    .chk_rd_en   (chk_rd_en),
    .stall       (stall),
    .rf_wr_en    (rf_wr_en),
    .rf_addr     (rf_addr),
    .rf_din      (rf_din),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic pwe, input int pa, input logic [31:0] pd,
                               input logic lv, input int la, input logic [31:0] ld,
                               input logic iv, input int ia,
                               input int rs, input int rt, input int rd, input logic rde);
    pri_wr_en   = pwe;
    pri_addr    = 5'(pa);
    pri_data    = pd;
    lu_valid    = lv;
    lu_addr     = 5'(la);
    lu_data     = ld;
    issue_valid = iv;
    issue_addr  = 5'(ia);
    chk_rs      = 5'(rs);
    chk_rt      = 5'(rt);
    chk_rd      = 5'(rd);
    chk_rd_en   = rde;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic modelReset();
    mq.delete();
    mpend = '0;
    merr  = 1'b0;
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the model state.
  task automatic checkOutput();
    bit          exp_ready, exp_stall, exp_busy, exp_err, accept, exp_wen, lu_write;
    bit [4:0]    waddr;
    bit [31:0]   wdata;
    wb_req_t     h;
    exp_ready = (mq.size() < Q_DEPTH);
    exp_busy  = (mq.size() != 0) || (mpend != 0);
    exp_err   = merr;
    exp_stall = mpend[chk_rs] || mpend[chk_rt] || (chk_rd_en && mpend[chk_rd]) ||
                (issue_valid && mpend[issue_addr]);
    accept    = lu_valid && exp_ready;
    lu_write  = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'd0;
    if (pri_wr_en && pri_addr != 5'd0) begin
      waddr = pri_addr;
      wdata = pri_data;
      if (accept) mq.push_back('{addr: lu_addr, data: lu_data});
    end else if (mq.size() != 0) begin
      h        = mq.pop_front();
      lu_write = 1'b1;
      waddr    = h.addr;
      wdata    = h.data;
      if (accept) mq.push_back('{addr: lu_addr, data: lu_data});
    end else if (accept) begin
      lu_write = 1'b1;
      waddr    = lu_addr;
      wdata    = lu_data;
    end
    exp_wen = (waddr != 5'd0);
    chk("rf_wr_en", 32'(rf_wr_en), 32'(exp_wen));
    if (exp_wen) begin
      chk("rf_addr", 32'(rf_addr), 32'(waddr));
      chk("rf_din", rf_din, wdata);
    end
    chk("lu_ready", 32'(lu_ready), 32'(exp_ready));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("err", 32'(err), 32'(exp_err));
    if (lu_write && waddr != 5'd0) begin
      if (!mpend[waddr]) merr = 1'b1;
      mpend[waddr] = 1'b0;
    end
    if (issue_valid && issue_addr != 5'd0) mpend[issue_addr] = 1'b1;
  endtask

  task automatic settle();
    #2;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_rf_wr_en"}, 32'(rf_wr_en), 32'd0);
    chk({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
    chk({tag, "_rf_din"}, rf_din, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_lu_ready"}, 32'(lu_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int       lu_idx;
    bit       rdy_exp;
    bit       pwe, lv, iv, rde;
    int       pa, la, ia, rs, rt, rd;
    bit [31:0] pd, ld;

    // Power-on reset with active inputs: outputs must stay quiet.
    rst = 1'b0;
    applyStimulus(1'b1, 3, 32'h1, 1'b1, 4, 32'h2, 1'b0, 0, 0, 0, 0, 1'b0);
    #1;
    checkResetOutputs("por");
    modelReset();
    tick();
    tick();
    rst = 1'b1;
    idle();
    settle();
    tick();

    // Reset mid-operation: pending r5 plus one queued entry, then pull reset.
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 5, 0, 0, 0, 1'b0);
    settle();
    tick();
    applyStimulus(1'b1, 1, 32'h1, 1'b1, 5, 32'h55, 1'b0, 0, 5, 0, 0, 1'b0);
    settle();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    tick();
    applyStimulus(1'b1, 2, 32'h2, 1'b0, 0, 32'd0, 1'b0, 0, 5, 0, 0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    modelReset();
    tick();
    rst = 1'b1;
    idle();
    settle();
    chk("midrst_busy_after", 32'(busy), 32'd0);
    tick();

    // Bypass straight to the register file while the queue is empty.
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 7, 0, 0, 0, 1'b0);
    settle();
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 7, 32'hDEADBEEF, 1'b0, 0, 0, 0, 0, 1'b0);
    settle();
    chk("bypass_wen", 32'(rf_wr_en), 32'd1);
    chk("bypass_addr", 32'(rf_addr), 32'd7);
    chk("bypass_din", rf_din, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 0, 7, 0, 0, 1'b0);
    settle();
    chk("bypass_released", 32'(stall), 32'd0);
    tick();

    // Collision: primary wins, long-latency result waits one cycle in the queue.
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 9, 0, 0, 0, 1'b0);
    settle();
    tick();
    applyStimulus(1'b1, 3, 32'h11, 1'b1, 9, 32'h22, 1'b0, 0, 0, 0, 0, 1'b0);
    settle();
    chk("collide_pri_addr", 32'(rf_addr), 32'd3);
    chk("collide_pri_din", rf_din, 32'h11);
    tick();
    idle();
    settle();
    chk("collide_lu_addr", 32'(rf_addr), 32'd9);
    chk("collide_lu_din", rf_din, 32'h22);
    tick();

    // Full queue: primary holds the port for four cycles while three results are offered.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 20 + i, 0, 0, 0, 1'b0);
      settle();
      tick();
    end
    lu_idx = 0;
    for (int c = 0; c < 8; c++) begin
      rdy_exp = (mq.size() < Q_DEPTH);
      applyStimulus(c < 4 ? 1'b1 : 1'b0, 1 + c, 32'h100 + 32'(c),
                    lu_idx < 3 ? 1'b1 : 1'b0, 20 + lu_idx, 32'hA000 + 32'(lu_idx),
                    1'b0, 0, 0, 0, 0, 1'b0);
      settle();
      if (c == 2) chk("full_lu_ready", 32'(lu_ready), 32'd0);
      if (c == 4) chk("drain_first", 32'(rf_addr), 32'd20);
      if (c == 5) chk("drain_second", 32'(rf_addr), 32'd21);
      if (c == 6) chk("drain_third", rf_din, 32'hA002);
      if (lu_valid && rdy_exp) lu_idx++;
      tick();
    end

    // RAW hazard held until the cycle after r12 retires; r0 never stalls.
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 12, 0, 0, 0, 1'b0);
    settle();
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 0, 12, 0, 0, 1'b0);
    settle();
    chk("raw_stall", 32'(stall), 32'd1);
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 12, 32'hC0FFEE, 1'b0, 0, 12, 0, 0, 1'b0);
    settle();
    chk("raw_no_forward", 32'(stall), 32'd1);
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 0, 12, 0, 0, 1'b0);
    settle();
    chk("raw_released", 32'(stall), 32'd0);
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 0, 0, 0, 0, 1'b1);
    settle();
    chk("zero_no_stall", 32'(stall), 32'd0);
    tick();

    // Zero register is silently consumed; a stray write to r4 sets sticky err.
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 0, 32'h1234, 1'b0, 0, 0, 0, 0, 1'b0);
    settle();
    chk("r0_no_write", 32'(rf_wr_en), 32'd0);
    tick();
    idle();
    settle();
    chk("r0_no_err", 32'(err), 32'd0);
    tick();
    applyStimulus(1'b0, 0, 32'd0, 1'b1, 4, 32'h4444, 1'b0, 0, 0, 0, 0, 1'b0);
    settle();
    chk("stray_write", 32'(rf_wr_en), 32'd1);
    tick();
    idle();
    settle();
    chk("err_set", 32'(err), 32'd1);
    tick();
    tick();
    settle();
    chk("err_sticky", 32'(err), 32'd1);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      pwe = ($urandom_range(0, 2) == 0);
      pa  = int'($urandom_range(0, 31));
      pd  = $urandom;
      lv  = ($urandom_range(0, 1) == 1);
      la  = int'($urandom_range(0, 15));
      for (int k = 0; k < 6; k++) begin
        if (mpend[la]) break;
        la = int'($urandom_range(0, 15));
      end
      ld  = $urandom;
      iv  = ($urandom_range(0, 2) == 0);
      ia  = int'($urandom_range(0, 15));
      rs  = int'($urandom_range(0, 15));
      rt  = int'($urandom_range(0, 15));
      rd  = int'($urandom_range(0, 15));
      rde = ($urandom_range(0, 1) == 1);
      applyStimulus(pwe, pa, pd, lv, la, ld, iv, ia, rs, rt, rd, rde);
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
